// File: rtl/pulse_train_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_ctrl
// Description : Programmable pulse-train generator. A one-cycle start latches
//               period / high width / pulse count and emits that many pulses
//               on the registered pulse output, then strobes done. Bad
//               configurations are rejected with a one-cycle err strobe, and
//               stop aborts from any state.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_train_ctrl #(
    parameter int CNT_W = 16,
    parameter int N_W   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic [N_W-1:0]   count,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] phase_q,  phase_d;   // cycle position inside the current period, 1-based
    logic [N_W-1:0]   sent_q,   sent_d;    // pulses fully completed so far
    logic [CNT_W-1:0] per_q,    per_d;
    logic [CNT_W-1:0] wid_q,    wid_d;
    logic [N_W-1:0]   cnt_q,    cnt_d;
    logic             pulse_q,  pulse_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;

    logic [N_W-1:0]   sent_inc;
    logic             cfg_bad;

    assign sent_inc = sent_q + N_W'(1);
    assign cfg_bad  = (width == '0) || (width >= period) || (count == '0);

    // Next-state and next-output computation; outputs are registered so the
    // pulse pin changes exactly on the edge that changes the state.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sent_d  = sent_q;
        per_d   = per_q;
        wid_d   = wid_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (stop) begin
            // Abort beats everything, including a simultaneous start.
            state_d = S_IDLE;
            pulse_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                    if (start) begin
                        if (cfg_bad) begin
                            err_d = 1'b1;
                        end else begin
                            per_d   = period;
                            wid_d   = width;
                            cnt_d   = count;
                            sent_d  = '0;
                            phase_d = CNT_W'(1);
                            state_d = S_HIGH;
                            pulse_d = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    // Phase stays <= width < period here, so the increment cannot wrap.
                    phase_d = phase_q + CNT_W'(1);
                    if (phase_q == wid_q) begin
                        state_d = S_LOW;
                        pulse_d = 1'b0;
                    end
                end
                S_LOW: begin
                    if (phase_q == per_q) begin
                        sent_d = sent_inc;
                        if (sent_inc < cnt_q) begin
                            state_d = S_HIGH;
                            phase_d = CNT_W'(1);
                            pulse_d = 1'b1;
                        end else begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, counter, config and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            sent_q  <= '0;
            per_q   <= '0;
            wid_q   <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sent_q  <= sent_d;
            per_q   <= per_d;
            wid_q   <= wid_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pulse = pulse_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_train_ctrl
// Description : Scoreboard bench for pulse_train_ctrl. Stimulus pushes the
//               expected output-vector changes {pulse,busy,done,err} with the
//               edge index at which each must appear; a monitor pops and
//               compares every change the DUT actually makes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_train_ctrl;

    localparam int FULL = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] period = '0;
    logic [15:0] width = '0;
    logic [7:0]  count = '0;
    logic        pulse, busy, done, err;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b0;
    logic [3:0] prev_v = 4'b0000;
    logic [3:0] cur_v;
    ev_t        e_pop;
    int         e0;

    pulse_train_ctrl #(.CNT_W(16), .N_W(8)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .stop   (stop),
        .period (period),
        .width  (width),
        .count  (count),
        .pulse  (pulse),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Edge index: after posedge N, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the output vector must match the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            cur_v = {pulse, busy, done, err};
            if (cur_v !== prev_v) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d actual=%b required=%b", cyc, cur_v, prev_v);
                end else begin
                    e_pop = exp_q.pop_front();
                    if ((e_pop.cyc != cyc) || (e_pop.v !== cur_v)) begin
                        errors++;
                        $display("FAIL event actual=cyc%0d/%b required=cyc%0d/%b", cyc, cur_v, e_pop.cyc, e_pop.v);
                    end
                end
                prev_v = cur_v;
            end
        end
    end

    task automatic push(input int c, input logic [3:0] v);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Called at a negedge. Expected changes with offset < lim from E0 are queued.
    task automatic run_train(input int p, input int w, input int n, input int lim, output int e0_o);
        period = 16'(p);
        width  = 16'(w);
        count  = 8'(n);
        start  = 1'b1;
        e0_o   = cyc + 1;
        for (int k = 0; k < n; k++) begin
            if (k * p < lim)     push(e0_o + k * p, 4'b1100);
            if (k * p + w < lim) push(e0_o + k * p + w, 4'b0100);
        end
        if (n * p < lim) begin
            push(e0_o + n * p, 4'b0010);
            push(e0_o + n * p + 1, 4'b0000);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_bad(input int p, input int w, input int n);
        int eb;
        period = 16'(p);
        width  = 16'(w);
        count  = 8'(n);
        start  = 1'b1;
        eb     = cyc + 1;
        push(eb, 4'b0001);
        push(eb + 1, 4'b0000);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d_pending required=0_pending", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {pulse, busy, done, err}, 4'b0000);
        rstn = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Basic train: period 8, width 3, count 4
        run_train(8, 3, 4, FULL, e0);
        wait_idle("basic", 100);

        // Rejected configurations
        run_bad(5, 0, 4);
        wait_idle("bad_width0", 20);
        run_bad(5, 5, 4);
        wait_idle("bad_width_eq_period", 20);
        run_bad(8, 3, 0);
        wait_idle("bad_count0", 20);

        // start and stop together in IDLE: nothing happens
        period = 16'd8; width = 16'd3; count = 8'd4;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (4) @(negedge clk);
        chk("start_stop_idle", {pulse, busy, done, err}, 4'b0000);

        // Starts during a running train are ignored, including a bad one
        run_train(8, 3, 2, FULL, e0);
        while (cyc < e0 + 5) @(negedge clk);
        period = 16'd4; width = 16'd1; count = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + 9) @(negedge clk);
        period = 16'd4; width = 16'd0; count = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignored_start", 100);

        // Abort at E10, then a new start sampled at E12
        run_train(8, 3, 4, 10, e0);
        while (cyc < e0 + 9) @(negedge clk);
        stop = 1'b1;
        push(e0 + 10, 4'b0000);
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        run_train(8, 3, 1, FULL, e0);
        wait_idle("abort_restart", 100);

        // Boundary: minimal period, maximal count
        run_train(2, 1, 255, FULL, e0);
        wait_idle("min_period", 700);

        // Boundary: maximal period
        run_train(65535, 65534, 1, FULL, e0);
        wait_idle("max_period", 70000);

        // Asynchronous reset in the middle of HIGH
        run_train(8, 3, 4, 2, e0);
        @(posedge clk);
        #2;
        push(cyc, 4'b0000);
        rstn = 1'b0;
        #1;
        chk("async_reset", {pulse, busy, done, err}, 4'b0000);
        repeat (2) @(negedge clk);
        chk("held_reset", {pulse, busy, done, err}, 4'b0000);
        rstn = 1'b1;
        @(negedge clk);
        run_train(8, 3, 2, FULL, e0);
        wait_idle("after_reset", 100);

        chk("queue_drained", 4'(exp_q.size()), 4'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
